// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The alignment-check helper is only referenced when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  // Alignment must agree with the width implied by the byte-enable pattern.
  function automatic logic misaligned(input logic we, input logic [1:0] a, input logic [3:0] be);
    if (!we) return a != 2'b00;
    if (be == 4'b0011 || be == 4'b1100) return a[0];
    if (be == 4'b1111) return a != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage split into byte lanes: byte-enabled synchronous write,
// combinational read of one word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [31:0]           wdata,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [AW-1:0]         raddr,
  output logic [31:0]           rdata
);

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[waddr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed request-to-response latency.
// Define DMEM_MISALIGN_CHECK_EN to flag accesses whose alignment disagrees with their byte enables.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t state;
  logic [3:0]  cnt;
  dmem_req_t   req_reg;
  logic        oor_c;
  logic        err_c;
  logic        commit_c;
  logic [AW-1:0] widx;
  logic [31:0] rd_word;

  assign req_ready = (state == IDLE) && !reset;
  assign widx      = req_reg.addr[AW+1:2];

  always_comb begin
    oor_c = {2'b00, req_reg.addr[31:2]} >= DEPTH_U;
`ifdef DMEM_MISALIGN_CHECK_EN
    err_c = oor_c || misaligned(req_reg.we, req_reg.addr[1:0], req_reg.be);
`else
    err_c = oor_c;
`endif
  end

`ifndef DMEM_MISALIGN_CHECK_EN
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_reg.addr[1:0];
`endif

  // The store lands on the same edge that raises resp_valid.
  assign commit_c = (state == WAIT) && (cnt == 4'd0) && req_reg.we && !err_c;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (commit_c),
    .waddr(widx),
    .wdata(req_reg.wdata),
    .be   (req_reg.be),
    .raddr(widx),
    .rdata(rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_reg <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
            cnt     <= CNT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_c;
            resp_rdata <= (err_c || req_reg.we) ? 32'd0 : rd_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
// Expectations follow DMEM_MISALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [0:255];
  int          check_cnt = 0;
  int          pass_cnt  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction

  // Drive one request, wait for its response, optionally complete the handshake.
  // lat = -1 marks an expired bound.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit handshake,
                        output logic [31:0] rdata, output logic err, output int lat, output int wait_n);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    rdata = 'x; err = 1'bx; lat = -1; wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 40) begin @(posedge clk); #1; wait_n++; end
    if (req_ready !== 1'b1) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (resp_valid !== 1'b1) begin lat = -1; return; end
    rdata = resp_rdata; err = resp_err;
    $display("txn we=%0d addr=%h wdata=%h be=%b -> rdata=%h err=%0d lat=%0d", we, addr, wdata, be, rdata, err, lat);
    if (handshake) begin resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0)
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 0/0/0/0", req_ready, resp_valid, resp_rdata, resp_err);
    else pass_cnt++;
    reset = 1'b0; #1;
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
    exp_q.push_back('{32'd0, 1'b0, LAT});
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat, wn);
    model[4] = 32'hDEADBEEF;
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL store_full: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    check_cnt++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL post_handshake: got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    else pass_cnt++;
    exp_q.push_back('{32'hDEADBEEF, 1'b0, LAT});
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b1, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL load_full: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
    logic [31:0] st_d [3] = '{32'h000000AA, 32'hFFFFFFFF, 32'h55660000};
    logic [3:0]  st_b [3] = '{4'b0001, 4'b0000, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'd0, 1'b0, LAT});
      do_req(1'b1, 32'h10, st_d[i], st_b[i], 1'b1, rd, er, lat, wn);
      model[4] = merge(model[4], st_d[i], st_b[i]);
      e = exp_q.pop_front();
      check_cnt++;
      if (rd !== e.rdata || er !== e.err || lat !== e.lat)
        $display("FAIL be_store%0d: got rdata=%h err=%b lat=%0d want %h/%b/%0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      else pass_cnt++;
      exp_q.push_back('{(i == 0) ? 32'hDEADBEAA : model[4], 1'b0, LAT});
      do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b1, rd, er, lat, wn);
      e = exp_q.pop_front();
      check_cnt++;
      if (rd !== e.rdata || er !== e.err || lat !== e.lat)
        $display("FAIL be_load%0d: got rdata=%h err=%b lat=%0d want %h/%b/%0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
    exp_q.push_back('{model[4], 1'b0, LAT});
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL stall_first: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    // A request offered during the stall must be ignored.
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h01020304; req_be = 4'hF; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_cnt++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== 1'b0 || req_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got valid=%b rdata=%h err=%b ready=%b want 1/%h/0/0", i, resp_valid, resp_rdata, resp_err, req_ready, e.rdata);
      else pass_cnt++;
    end
    resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0; req_valid = 1'b0;
    check_cnt++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL stall_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    else pass_cnt++;
    exp_q.push_back('{model[4], 1'b0, LAT});
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b1, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL stall_ignored_req: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
    logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad_t [4] = '{32'h0, 32'h400, 32'h400, 32'h0};
    logic [31:0] wd_t [4] = '{32'hCAFEF00D, 32'h0, 32'h11111111, 32'h0};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back('{32'hCAFEF00D, 1'b0, LAT});
      else exp_q.push_back('{32'd0, (ad_t[i] == 32'h400), LAT});
      do_req(we_t[i], ad_t[i], wd_t[i], 4'hF, 1'b1, rd, er, lat, wn);
      e = exp_q.pop_front();
      check_cnt++;
      if (rd !== e.rdata || er !== e.err || lat !== e.lat)
        $display("FAIL oor_step%0d: got rdata=%h err=%b lat=%0d want %h/%b/%0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      else pass_cnt++;
    end
    model[0] = 32'hCAFEF00D;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
    exp_q.push_back('{32'd0, 1'b0, LAT});
    do_req(1'b1, 32'h20, 32'h0BADC0DE, 4'hF, 1'b1, rd, er, lat, wn);
    model[8] = 32'h0BADC0DE;
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL abort_seed: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; req_valid = 1'b1;
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL abort_accept_ready: got %b want 1", req_ready); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 2) reset = 1'b0;
      check_cnt++;
      if (resp_valid !== 1'b0) $display("FAIL abort_no_resp%0d: got valid=%b want 0", i, resp_valid); else pass_cnt++;
    end
    exp_q.push_back('{32'h0BADC0DE, 1'b0, LAT});
    do_req(1'b0, 32'h20, 32'd0, 4'h0, 1'b0, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL abort_prior_value: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    // Reset while the response is being presented drops it.
    reset = 1'b1;
    @(posedge clk); #1;
    check_cnt++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0)
      $display("FAIL abort_in_resp: got valid=%b rdata=%h want 0/0", resp_valid, resp_rdata);
    else pass_cnt++;
    reset = 1'b0; #1;
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL abort_ready_after: got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_q.push_back('{32'd0, 1'b1, LAT});
`else
    exp_q.push_back('{model[4], 1'b0, LAT});
`endif
    do_req(1'b0, 32'h13, 32'd0, 4'h0, 1'b1, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL mis_load: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_q.push_back('{32'd0, 1'b1, LAT});
`else
    exp_q.push_back('{32'd0, 1'b0, LAT});
    model[4] = merge(model[4], 32'h00007788, 4'b0011);
`endif
    do_req(1'b1, 32'h11, 32'h00007788, 4'b0011, 1'b1, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL mis_store: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
    exp_q.push_back('{model[4], 1'b0, LAT});
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 1'b1, rd, er, lat, wn);
    e = exp_q.pop_front();
    check_cnt++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat)
      $display("FAIL mis_readback: got rdata=%h err=%b lat=%0d want %h/%b/%0d", rd, er, lat, e.rdata, e.err, e.lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, wn; exp_t e;
    logic we; logic [31:0] d; logic [3:0] be; int w;
    for (int i = 0; i < 20; i++) begin
      w  = 64 + ((i < 8) ? i : int'($urandom_range(0, 7)));
      we = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      d  = $urandom;
      be = (i < 8) ? 4'hF : 4'($urandom_range(0, 15));
      if (we) begin
        exp_q.push_back('{32'd0, 1'b0, LAT});
        model[w] = merge(model[w], d, be);
      end else begin
        exp_q.push_back('{model[w], 1'b0, LAT});
      end
      do_req(we, 32'(w * 4), d, be, 1'b1, rd, er, lat, wn);
      e = exp_q.pop_front();
      check_cnt++;
      if (rd !== e.rdata || er !== e.err || lat !== e.lat || wn !== 0)
        $display("FAIL b2b%0d: got rdata=%h err=%b lat=%0d wait=%0d want %h/%b/%0d/0", i, rd, er, lat, wn, e.rdata, e.err, e.lat);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_stall();
    test_out_of_range();
    test_reset_abort();
    test_misalign();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to first resp_valid (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock, with all logic on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, asserted when the core presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, 1, asserted when the block can accept a request.
REQ-007 The block SHALL have port req_we, input, 1, selecting store (1) or load (0).
REQ-008 The block SHALL have port req_addr, input, 32, a byte address with word index = req_addr[31:2].
REQ-009 The block SHALL have port req_wdata, input, 32, the store data, already lane-aligned by the core.
REQ-010 The block SHALL have port req_be, input, 4, the per-byte store enables, where bit i enables byte lane i.
REQ-011 The block SHALL have port resp_valid, output, 1, asserted while a response is presented.
REQ-012 The block SHALL have port resp_ready, input, 1, asserted when the core accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, 32, the full load word, or 0 for stores and errors.
REQ-014 The block SHALL have port resp_err, output, 1, flagging an out-of-range (or misaligned, see Configuration) access.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0, so that one request is outstanding at most.
REQ-017 A request SHALL be accepted on a cycle with req_valid and req_ready both 1; that cycle SHALL capture we/addr/wdata/be and load the latency counter with LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0, or immediately when LATENCY=1, the FSM SHALL go to RESP, so that resp_valid first rises exactly LATENCY cycles after the accept edge.
REQ-019 A store SHALL commit to the array on the edge entering RESP, with only enabled bytes written; req_be=0 SHALL write nothing but still respond.
REQ-020 Load data SHALL reflect the array contents including all previously committed stores, so that read-after-write is coherent.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready=1; the handshake cycle SHALL return the FSM to IDLE, and resp_valid SHALL be 0 on the next cycle.
REQ-022 A new request SHALL not be accepted in the same cycle as a response handshake; the earliest next accept is the following cycle.
REQ-023 An access with req_addr[31:2] >= DEPTH_WORDS SHALL respond with resp_err=1 and resp_rdata=0, with no array write and the same latency as a normal access.
REQ-024 resp_ready SHALL be ignored outside RESP, and req_valid SHALL be ignored outside IDLE.

Reset
REQ-025 While reset=1, at the clock edge, the FSM SHALL go to IDLE, the counter SHALL clear, and outputs SHALL read req_ready=0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-026 req_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-027 A reset during WAIT or RESP SHALL abandon the transaction, drop a pending store uncommitted, and never deliver its response.
REQ-028 Array contents SHALL not be cleared by reset.

Configuration
REQ-029 With DMEM_MISALIGN_CHECK_EN defined, a request whose alignment does not match its be pattern SHALL respond with resp_err=1, resp_rdata=0 and no write:
- a load with addr[1:0]!=0;
- a store with be of 0011/1100 and addr[0]=1;
- a store with be=1111 and addr[1:0]!=0.
REQ-030 Without DMEM_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored and no misalignment error SHALL be raised.

Structure
REQ-031 Package dmem_pkg SHALL hold the state enum dmem_state_t, the captured-request struct dmem_req_t, and constants WORD_BYTES=4 and MAX_LATENCY=15.
REQ-032 Storage SHALL be in sub-module dmem_array, providing a byte-enabled synchronous write and a combinational read of one word.

Verification
REQ-033 Store 0xDEADBEEF to address 0x10 with be=1111, then load 0x10 -> rdata=0xDEADBEEF, resp_valid rising 2 cycles after each accept, err=0.
REQ-034 Store 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF -> a subsequent load of 0x10 returns 0xDEADBEAA.
REQ-035 Load with resp_ready held 0 for 5 cycles -> resp_valid and rdata stable for 6 cycles, req_ready=0 throughout, IDLE afterwards.
REQ-036 Load of 0x400 with DEPTH_WORDS=256 -> err=1, rdata=0; a store to 0x400 leaves word 0 unchanged.
REQ-037 Store 0x12345678 to 0x20, assert reset 1 cycle after accept -> no response, and a later load of 0x20 returns the prior value.
REQ-038 With DMEM_MISALIGN_CHECK_EN, load of 0x13 -> err=1; without it -> returns the word at 0x10.
